sm3_res_otpt: RTL and testbench
===============================

# sm3_res_otpt

Digest output stage of the SM3 core, directly downstream of the iterative compression core. It captures each 256-bit digest from the compression core's one-cycle valid pulse into a 2-entry buffer. It serialises each digest, most-significant word first, onto a narrow valid/ready stream whose width matches the core input bus. It also flags any digest lost because the buffer was full.

## Interface
- `OTPT_DW`, default 32: output word width; legal values are 32 and 64.
- `WRD_NUM`, default 256/`OTPT_DW` (derived, not overridable): words per digest, 8 or 4.

- `clk`  in  1  single clock domain; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmprss_inpt_res_i`  in  256  digest from the compression core; bit 255 is the MSB of register A.
- `cmprss_inpt_vld_i`  in  1  one-cycle pulse; `cmprss_inpt_res_i` is valid only in that cycle.
- `res_otpt_d_o`  out  `OTPT_DW`  current output word.
- `res_otpt_vld_o`  out  1  `res_otpt_d_o` is valid.
- `res_otpt_lst_o`  out  1  current word is the last word of a digest.
- `res_otpt_rdy_i`  in  1  downstream accepts the word when both vld and rdy are high.
- `res_buf_ful_o`  out  1  both buffer entries are occupied.
- `res_ovfl_o`  out  1  sticky flag: a digest was dropped.
- `res_ovfl_clr_i`  in  1  synchronous clear of `res_ovfl_o`.

## Operation
- **Buffer:** 2 entries of 256 bits, with a 1-bit write pointer `wr_ptr`, a 1-bit read pointer `rd_ptr`, and an occupancy count `cnt` ranging 0..2.
- **Word counter:** `wrd_cnt`, ranging 0..`WRD_NUM`-1, is the index of the next word within the head entry.
- **State machine:**
  - IDLE: `cnt`==0.
  - SEND: `cnt`>0.
  - IDLE→SEND on capture.
  - SEND→IDLE when the last word is accepted and no capture occurs in that cycle while `cnt`==1.
- **Capture:**
  - When `cmprss_inpt_vld_i` is high and a slot is free, write the digest to `buf[wr_ptr]`, toggle `wr_ptr`, and increment `cnt`.
  - A slot is free when `cnt`<2, or when `cnt`==2 and the last word is being accepted in the same cycle.
- **Output:**
  - `res_otpt_vld_o` = (`cnt`!=0).
  - `res_otpt_d_o` = `buf[rd_ptr][255-wrd_cnt*OTPT_DW -: OTPT_DW]`, so word 0 is the MSB slice.
  - `res_otpt_lst_o` = `res_otpt_vld_o` && (`wrd_cnt`==`WRD_NUM`-1).
- **Accept (vld && rdy):**
  - Not the last word: increment `wrd_cnt`.
  - Last word: `wrd_cnt`←0, toggle `rd_ptr`, decrement `cnt`. A simultaneous capture cancels the decrement.
- **Overflow:**
  - If `cmprss_inpt_vld_i` is high and no slot is free, drop the digest and set `res_ovfl_o`. Buffer contents and pointers are unchanged.
  - `res_ovfl_clr_i` clears the flag; if a set and a clear occur in the same cycle, the set wins.
- **Reset values:** `res_otpt_vld_o`=0, `res_otpt_lst_o`=0, `res_otpt_d_o`=0, `res_buf_ful_o`=0, `res_ovfl_o`=0. `cnt`, `wrd_cnt` and both pointers reset to 0, and buffer contents reset to 0.
- **Reset mid-operation:** any digest in flight is discarded. After release, the output stays idle until the next capture pulse.
- **Output stability:** while vld is high and rdy is low, `res_otpt_d_o` and `res_otpt_lst_o` hold stable.

## Timing
- Capture pulse at edge T: `res_otpt_vld_o` goes high after edge T. Word 0 is presented in cycle T+1.
- Minimum digest drain time with rdy held high: `WRD_NUM` cycles (8 at DW=32, 4 at DW=64).
- Back-to-back digests in the buffer stream without a bubble: the last word of entry 0 is followed in the next cycle by word 0 of entry 1.
- `res_buf_ful_o` = (`cnt`==2) and is registered-equivalent: it reflects state after the current edge.
- No combinational path from `res_otpt_rdy_i` to `res_otpt_vld_o` or `res_otpt_d_o`.
- The compression core emits at most one digest per 64+ cycles, so with rdy held high the buffer never overflows.

## Test plan
- **Single digest, DW=32, rdy=1:** inject the SM3("abc") digest 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0. Expect 8 words in that order on cycles T+1..T+8, `lst` high only on 8f4ba8e0, and vld low at T+9.
- **Same digest, DW=64:** expect 4 words, 66c7f0f462eeedd9 through 297da02b8f4ba8e0, with `lst` on the 4th word.
- **Backpressure:** toggle rdy pseudo-randomly. Data and `lst` must hold while rdy=0, and the word sequence must be identical to the rdy=1 case.
- **Two captures with rdy=0, then a third capture:**
  - After the two captures, `res_buf_ful_o`=1.
  - The third capture sets `res_ovfl_o`=1.
  - Releasing rdy then outputs digests 1 and 2 only, back-to-back with no bubble.
  - `res_ovfl_clr_i` clears the flag.
- **Simultaneous capture and last-word accept with `cnt`==2:** the new digest is stored, `cnt` stays 2, and `res_ovfl_o` stays 0.
- **Reset asserted mid-digest (after 3 words):** all outputs are 0 immediately. After release, a fresh capture outputs from word 0.

Source files
------------

// File: rtl/sm3_res_otpt.sv
// SM3 digest output stage: buffers up to two 256-bit digests from the compression
// core and streams each one MSB word first over a valid/ready interface.
module sm3_res_otpt #(
   parameter int OTPT_DW = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [255:0]       cmprss_inpt_res_i,
   input  logic               cmprss_inpt_vld_i,
   output logic [OTPT_DW-1:0] res_otpt_d_o,
   output logic               res_otpt_vld_o,
   output logic               res_otpt_lst_o,
   input  logic               res_otpt_rdy_i,
   output logic               res_buf_ful_o,
   output logic               res_ovfl_o,
   input  logic               res_ovfl_clr_i
);

   localparam int WRD_NUM = 256 / OTPT_DW;
   localparam int WCW = $clog2(WRD_NUM);
   localparam logic [WCW-1:0] LAST_WRD = WCW'(WRD_NUM - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   state_t           next_state;
   logic [255:0]     res_buf [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       cnt;
   logic [WCW-1:0]   wrd_cnt;
   logic [255:0]     head;
   logic [255:0]     shifted;
   logic             accept;
   logic             last_acc;
   logic             slot_free;
   logic             capture;
   logic             drop;

   assign accept    = res_otpt_vld_o && res_otpt_rdy_i;
   assign last_acc  = accept && (wrd_cnt == LAST_WRD);
   // A full buffer can still take a digest if the head entry retires this cycle.
   assign slot_free = (cnt != 2'd2) || last_acc;
   assign capture   = cmprss_inpt_vld_i && slot_free;
   assign drop      = cmprss_inpt_vld_i && !slot_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (capture) next_state = SEND;
         SEND: if (last_acc && !capture && (cnt == 2'd1)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      res_otpt_vld_o = (state == SEND);
      res_otpt_lst_o = res_otpt_vld_o && (wrd_cnt == LAST_WRD);
      res_buf_ful_o  = (cnt == 2'd2);
   end

   assign head         = res_buf[rd_ptr];
   assign shifted      = head << (wrd_cnt * OTPT_DW);
   assign res_otpt_d_o = shifted[255 -: OTPT_DW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_buf[0] <= '0;
         res_buf[1] <= '0;
         wr_ptr     <= 1'b0;
      end else if (capture) begin
         res_buf[wr_ptr] <= cmprss_inpt_res_i;
         wr_ptr          <= ~wr_ptr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= 1'b0;
         wrd_cnt <= '0;
      end else if (accept) begin
         if (wrd_cnt == LAST_WRD) begin
            wrd_cnt <= '0;
            rd_ptr  <= ~rd_ptr;
         end else begin
            wrd_cnt <= wrd_cnt + WCW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 2'd0;
      end else begin
         case ({capture, last_acc})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // A drop in the same cycle as a clear must leave the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              res_ovfl_o <= 1'b0;
      else if (drop)           res_ovfl_o <= 1'b1;
      else if (res_ovfl_clr_i) res_ovfl_o <= 1'b0;
   end

endmodule

// File: tb/tb_sm3_res_otpt.sv
// Directed bench for sm3_res_otpt: one 32-bit and one 64-bit instance sharing a clock,
// expected words taken from hand-written digest tables.
module tb_sm3_res_otpt;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] res_in = '0;
   logic         vld32 = 1'b0;
   logic         vld64 = 1'b0;
   logic         rdy = 1'b0;
   logic         clr = 1'b0;

   logic [31:0]  d32;
   logic         ov32, lst32, ful32, ovfl32;
   logic [63:0]  d64;
   logic         ov64, lst64, ful64, ovfl64;

   int total = 0;
   int bad = 0;

   logic [31:0] words [3][8];
   logic [63:0] exp64 [4];

   always #5 clk = ~clk;

   sm3_res_otpt #(.OTPT_DW(32)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .cmprss_inpt_res_i(res_in), .cmprss_inpt_vld_i(vld32),
      .res_otpt_d_o(d32), .res_otpt_vld_o(ov32), .res_otpt_lst_o(lst32),
      .res_otpt_rdy_i(rdy), .res_buf_ful_o(ful32), .res_ovfl_o(ovfl32),
      .res_ovfl_clr_i(clr)
   );

   sm3_res_otpt #(.OTPT_DW(64)) dut64 (
      .clk(clk), .rst_n(rst_n),
      .cmprss_inpt_res_i(res_in), .cmprss_inpt_vld_i(vld64),
      .res_otpt_d_o(d64), .res_otpt_vld_o(ov64), .res_otpt_lst_o(lst64),
      .res_otpt_rdy_i(rdy), .res_buf_ful_o(ful64), .res_ovfl_o(ovfl64),
      .res_ovfl_clr_i(clr)
   );

   function automatic logic [255:0] digest(input int k);
      logic [255:0] d;
      d = '0;
      for (int i = 0; i < 8; i++) d = {d[223:0], words[k][i]};
      return d;
   endfunction

   // Drives one capture pulse starting at a falling edge; returns in cycle T+1.
   task automatic pulse32(input int k, input logic with_clr);
      res_in = digest(k);
      vld32  = 1'b1;
      clr    = with_clr;
      @(negedge clk);
      vld32  = 1'b0;
      clr    = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (ov32 !== 1'b0)   begin bad++; $display("[TB] FAIL rst_vld got=%b exp=0", ov32); end
      total++; if (lst32 !== 1'b0)  begin bad++; $display("[TB] FAIL rst_lst got=%b exp=0", lst32); end
      total++; if (d32 !== 32'h0)   begin bad++; $display("[TB] FAIL rst_data got=%h exp=0", d32); end
      total++; if (ful32 !== 1'b0)  begin bad++; $display("[TB] FAIL rst_ful got=%b exp=0", ful32); end
      total++; if (ovfl32 !== 1'b0) begin bad++; $display("[TB] FAIL rst_ovfl got=%b exp=0", ovfl32); end
      total++; if (ov64 !== 1'b0)   begin bad++; $display("[TB] FAIL rst_vld64 got=%b exp=0", ov64); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (ov32 !== 1'b0)   begin bad++; $display("[TB] FAIL post_rst_vld got=%b exp=0", ov32); end
   endtask

   task automatic test_single32;
      rdy = 1'b1;
      pulse32(0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         total++; if (ov32 !== 1'b1) begin bad++; $display("[TB] FAIL s32_vld[%0d] got=%b exp=1", i, ov32); end
         total++; if (d32 !== words[0][i]) begin bad++; $display("[TB] FAIL s32_data[%0d] got=%h exp=%h", i, d32, words[0][i]); end
         total++; if (lst32 !== (i == 7)) begin bad++; $display("[TB] FAIL s32_lst[%0d] got=%b exp=%b", i, lst32, (i == 7)); end
         @(negedge clk);
      end
      total++; if (ov32 !== 1'b0) begin bad++; $display("[TB] FAIL s32_vld_end got=%b exp=0", ov32); end
   endtask

   task automatic test_single64;
      rdy    = 1'b1;
      res_in = digest(0);
      vld64  = 1'b1;
      @(negedge clk);
      vld64  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++; if (ov64 !== 1'b1) begin bad++; $display("[TB] FAIL s64_vld[%0d] got=%b exp=1", i, ov64); end
         total++; if (d64 !== exp64[i]) begin bad++; $display("[TB] FAIL s64_data[%0d] got=%h exp=%h", i, d64, exp64[i]); end
         total++; if (lst64 !== (i == 3)) begin bad++; $display("[TB] FAIL s64_lst[%0d] got=%b exp=%b", i, lst64, (i == 3)); end
         @(negedge clk);
      end
      total++; if (ov64 !== 1'b0) begin bad++; $display("[TB] FAIL s64_vld_end got=%b exp=0", ov64); end
   endtask

   task automatic test_backpressure;
      int idx;
      int cyc;
      idx = 0;
      cyc = 0;
      rdy = 1'b0;
      pulse32(0, 1'b0);
      while (idx < 8 && cyc < 300) begin
         total++; if (ov32 !== 1'b1) begin bad++; $display("[TB] FAIL bp_vld[%0d] got=%b exp=1", idx, ov32); end
         total++; if (d32 !== words[0][idx]) begin bad++; $display("[TB] FAIL bp_data[%0d] got=%h exp=%h", idx, d32, words[0][idx]); end
         total++; if (lst32 !== (idx == 7)) begin bad++; $display("[TB] FAIL bp_lst[%0d] got=%b exp=%b", idx, lst32, (idx == 7)); end
         rdy = 1'($urandom_range(0, 1));
         if (rdy) idx++;
         cyc++;
         @(negedge clk);
      end
      rdy = 1'b0;
      total++; if (idx != 8) begin bad++; $display("[TB] FAIL bp_timeout got=%0d exp=8", idx); end
      total++; if (ov32 !== 1'b0) begin bad++; $display("[TB] FAIL bp_vld_end got=%b exp=0", ov32); end
   endtask

   task automatic test_overflow;
      rdy = 1'b0;
      pulse32(0, 1'b0);
      pulse32(1, 1'b0);
      total++; if (ful32 !== 1'b1)  begin bad++; $display("[TB] FAIL ov_ful got=%b exp=1", ful32); end
      total++; if (ovfl32 !== 1'b0) begin bad++; $display("[TB] FAIL ov_pre got=%b exp=0", ovfl32); end
      pulse32(2, 1'b0);
      total++; if (ovfl32 !== 1'b1) begin bad++; $display("[TB] FAIL ov_set got=%b exp=1", ovfl32); end
      pulse32(2, 1'b1);
      total++; if (ovfl32 !== 1'b1) begin bad++; $display("[TB] FAIL ov_set_wins got=%b exp=1", ovfl32); end
      rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         total++; if (ov32 !== 1'b1) begin bad++; $display("[TB] FAIL ov_vld[%0d] got=%b exp=1", i, ov32); end
         total++; if (d32 !== words[i / 8][i % 8]) begin bad++; $display("[TB] FAIL ov_data[%0d] got=%h exp=%h", i, d32, words[i / 8][i % 8]); end
         total++; if (lst32 !== (i % 8 == 7)) begin bad++; $display("[TB] FAIL ov_lst[%0d] got=%b exp=%b", i, lst32, (i % 8 == 7)); end
         @(negedge clk);
      end
      total++; if (ov32 !== 1'b0) begin bad++; $display("[TB] FAIL ov_drained got=%b exp=0", ov32); end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      total++; if (ovfl32 !== 1'b0) begin bad++; $display("[TB] FAIL ov_clr got=%b exp=0", ovfl32); end
   endtask

   task automatic test_back_to_back;
      rdy = 1'b0;
      pulse32(0, 1'b0);
      pulse32(1, 1'b0);
      rdy = 1'b1;
      repeat (7) @(negedge clk);
      total++; if (lst32 !== 1'b1) begin bad++; $display("[TB] FAIL bb_lst got=%b exp=1", lst32); end
      total++; if (d32 !== words[0][7]) begin bad++; $display("[TB] FAIL bb_a7 got=%h exp=%h", d32, words[0][7]); end
      pulse32(2, 1'b0);
      total++; if (ful32 !== 1'b1)  begin bad++; $display("[TB] FAIL bb_ful got=%b exp=1", ful32); end
      total++; if (ovfl32 !== 1'b0) begin bad++; $display("[TB] FAIL bb_ovfl got=%b exp=0", ovfl32); end
      for (int i = 0; i < 16; i++) begin
         total++; if (ov32 !== 1'b1) begin bad++; $display("[TB] FAIL bb_vld[%0d] got=%b exp=1", i, ov32); end
         total++; if (d32 !== words[1 + i / 8][i % 8]) begin bad++; $display("[TB] FAIL bb_data[%0d] got=%h exp=%h", i, d32, words[1 + i / 8][i % 8]); end
         @(negedge clk);
      end
      total++; if (ov32 !== 1'b0) begin bad++; $display("[TB] FAIL bb_vld_end got=%b exp=0", ov32); end
   endtask

   task automatic test_reset_mid;
      rdy = 1'b1;
      pulse32(0, 1'b0);
      repeat (3) @(negedge clk);
      total++; if (d32 !== words[0][3]) begin bad++; $display("[TB] FAIL rm_w3 got=%h exp=%h", d32, words[0][3]); end
      rst_n = 1'b0;
      #1;
      total++; if (ov32 !== 1'b0)  begin bad++; $display("[TB] FAIL rm_vld got=%b exp=0", ov32); end
      total++; if (lst32 !== 1'b0) begin bad++; $display("[TB] FAIL rm_lst got=%b exp=0", lst32); end
      total++; if (d32 !== 32'h0)  begin bad++; $display("[TB] FAIL rm_data got=%h exp=0", d32); end
      total++; if (ful32 !== 1'b0) begin bad++; $display("[TB] FAIL rm_ful got=%b exp=0", ful32); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (ov32 !== 1'b0) begin bad++; $display("[TB] FAIL rm_idle got=%b exp=0", ov32); end
      pulse32(0, 1'b0);
      total++; if (d32 !== words[0][0]) begin bad++; $display("[TB] FAIL rm_w0 got=%h exp=%h", d32, words[0][0]); end
      @(negedge clk);
      total++; if (d32 !== words[0][1]) begin bad++; $display("[TB] FAIL rm_w1 got=%h exp=%h", d32, words[0][1]); end
      repeat (8) @(negedge clk);
   endtask

   initial begin
      words[0] = '{32'h66c7f0f4, 32'h62eeedd9, 32'hd1f2d46b, 32'hdc10e4e2,
                   32'h4167c487, 32'h5cf2f7a2, 32'h297da02b, 32'h8f4ba8e0};
      words[1] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                   32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
      words[2] = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfedcba98,
                   32'h76543210, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'hc0ffee00};
      exp64    = '{64'h66c7f0f462eeedd9, 64'hd1f2d46bdc10e4e2,
                   64'h4167c4875cf2f7a2, 64'h297da02b8f4ba8e0};
      @(negedge clk);
      test_reset();
      test_single32();
      test_single64();
      test_backpressure();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
